// File: rtl/rv32i_mem_pkg.sv
// Shared types and constants for the rv32i IF/LSU memory arbiter.
package rv32i_mem_pkg;

  // Largest supported memory latency; the latency counter is sized from it.
  localparam int MEM_LAT_MAX = 4;
  localparam int LAT_CNT_W   = (MEM_LAT_MAX > 1) ? $clog2(MEM_LAT_MAX) : 1;

  // Arbiter FSM: IDLE = no access in flight, BUSY = waiting for read data.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Which requester owns the transaction currently in flight.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/rv32i_arb2.sv
// Two-way winner select between the fetch (I) and load/store (D) requesters.
// Build option RV32I_MEM_ARB_RR_EN: round-robin on conflicts, using a pointer
// that remembers the last granted requester. Without it, D always beats I and
// no pointer flop exists.
module rv32i_arb2
  import rv32i_mem_pkg::*;
(
`ifdef RV32I_MEM_ARB_RR_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic issue_en,
  input  logic i_req,
  input  logic d_req,
  output logic i_win,
  output logic d_win
);

  logic i_pick;
  logic d_pick;

`ifdef RV32I_MEM_ARB_RR_EN
  owner_t last_q;

  // Remember who was granted last; starts at I so D takes the first conflict.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= OWN_I;
    end else if (i_win || d_win) begin
      last_q <= d_win ? OWN_D : OWN_I;
    end
  end

  // On a conflict the requester not granted last wins; a lone request always wins.
  always_comb begin
    d_pick = d_req && (!i_req || (last_q == OWN_I));
    i_pick = i_req && (!d_req || (last_q == OWN_D));
  end
`else
  // Fixed priority: D over I.
  always_comb begin
    d_pick = d_req;
    i_pick = i_req && !d_req;
  end
`endif

  assign i_win = issue_en && i_pick;
  assign d_win = issue_en && d_pick;

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Arbiter letting the rv32i fetch port and LSU port share one single-port,
// fixed-latency memory. One transaction is outstanding at a time; the owner is
// tracked until the read data (or store completion) returns MEM_LAT cycles
// after issue, at which point a new access may issue back-to-back.
// Build option RV32I_MEM_ARB_RR_EN selects round-robin arbitration inside
// rv32i_arb2; by default the LSU has fixed priority over fetch.
module rv32i_mem_arbiter
  import rv32i_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  // instruction fetch port
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  // load/store port
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  // unified memory
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(MEM_LAT - 1);

  if ((MEM_LAT < 1) || (MEM_LAT > MEM_LAT_MAX)) begin : g_bad_lat
    $error("rv32i_mem_arbiter: MEM_LAT must be within 1..MEM_LAT_MAX");
  end

  state_t                 state_q, state_d;
  owner_t                 owner_q, owner_d;
  logic [LAT_CNT_W-1:0]   lat_cnt_q, lat_cnt_d;

  logic resp_cycle;
  logic issue_en;
  logic i_win;
  logic d_win;
  logic issue;

  // The response cycle is the last latency cycle of the access in flight.
  assign resp_cycle = (state_q == BUSY) && (lat_cnt_q == LAT_LAST);

  // Issue slot: idle, or the response cycle of the current access. Gating with
  // rst forces grants and mem_req low the moment reset asserts, even while a
  // requester keeps its request high.
  assign issue_en = rst && ((state_q == IDLE) || resp_cycle);

  rv32i_arb2 u_arb (
`ifdef RV32I_MEM_ARB_RR_EN
    .clk      (clk),
    .rst      (rst),
`endif
    .issue_en (issue_en),
    .i_req    (i_req),
    .d_req    (d_req),
    .i_win    (i_win),
    .d_win    (d_win)
  );

  assign issue = i_win || d_win;

  // State, owner and latency counter registers; reset drops any access in flight.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  // Next-state logic: start a new access on issue, count latency while busy,
  // fall back to IDLE when the response cycle passes with nothing to issue.
  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    lat_cnt_d = lat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          state_d   = BUSY;
          owner_d   = d_win ? OWN_D : OWN_I;
          lat_cnt_d = '0;
        end
      end
      BUSY: begin
        if (resp_cycle) begin
          if (issue) begin
            state_d   = BUSY;
            owner_d   = d_win ? OWN_D : OWN_I;
            lat_cnt_d = '0;
          end else begin
            state_d   = IDLE;
            lat_cnt_d = '0;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        lat_cnt_d = '0;
      end
    endcase
  end

  // Request side: grant pulses plus the memory fields of the winner; all zero
  // when nothing issues.
  always_comb begin
    i_gnt     = i_win;
    d_gnt     = d_win;
    mem_req   = issue;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (d_win) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end else if (i_win) begin
      mem_addr  = i_addr;
    end
  end

  // Response side: completion pulse and data routed to the owner only.
  always_comb begin
    i_rvalid = resp_cycle && (owner_q == OWN_I);
    d_rvalid = resp_cycle && (owner_q == OWN_D);
    i_rdata  = i_rvalid ? mem_rdata : '0;
    d_rdata  = d_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Self-checking bench for rv32i_mem_arbiter. The main instance runs with
// MEM_LAT=2 against a transaction-level model (response due at issue cycle +
// latency, owner and expected data recorded at issue). A second instance with
// MEM_LAT=1 exercises continuous fetch throughput. Build with
// RV32I_MEM_ARB_RR_EN defined to check round-robin expectations.
module tb_rv32i_mem_arbiter;

  localparam int LAT = 2;

  logic        clk;
  logic        rst;

  // main instance (MEM_LAT = 2)
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  // throughput instance (MEM_LAT = 1)
  logic        i1_req, i1_gnt, i1_rvalid;
  logic [31:0] i1_addr, i1_rdata;
  logic        d1_gnt, d1_rvalid;
  logic [31:0] d1_rdata;
  logic        mem1_req, mem1_we;
  logic [31:0] mem1_addr, mem1_wdata, mem1_rdata;
  logic [3:0]  mem1_be;

  rv32i_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  rv32i_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .i_req(i1_req), .i_addr(i1_addr), .i_gnt(i1_gnt), .i_rvalid(i1_rvalid), .i_rdata(i1_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0), .d_be(4'h0),
    .d_gnt(d1_gnt), .d_rvalid(d1_rvalid), .d_rdata(d1_rdata),
    .mem_req(mem1_req), .mem_we(mem1_we), .mem_addr(mem1_addr), .mem_wdata(mem1_wdata),
    .mem_be(mem1_be), .mem_rdata(mem1_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory behind the main instance ----------------
  logic [31:0] mem [logic [31:0]];
  logic [31:0] sched_data [8];
  bit          sched_v    [8];
  int          cyc = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : ~a;
  endfunction

  // Cycle counter and read-data return, valid for the whole response cycle.
  initial begin
    mem_rdata = 32'hBAD0BAD0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      mem_rdata = sched_v[cyc % 8] ? sched_data[cyc % 8] : 32'hBAD0BAD0;
      sched_v[cyc % 8] = 1'b0;
    end
  end

  // ---------------- event logs for directed checks ----------------
  int          q_ig[$], q_dg[$], q_ir[$], q_dr[$];
  logic [31:0] q_ird[$], q_drd[$];
  bit          q_order[$];   // 1 = D granted, 0 = I granted
  logic        snap_we;
  logic [31:0] snap_addr, snap_wdata;
  logic [3:0]  snap_be;

  task automatic clear_logs();
    q_ig.delete(); q_dg.delete(); q_ir.delete(); q_dr.delete();
    q_ird.delete(); q_drd.delete(); q_order.delete();
  endtask

  // ---------------- transaction-level model + per-cycle compare ----------------
  int          m_resp_cyc = -1;   // cycle in which the pending response is due
  bit          m_resp_d, m_resp_we;
  logic [31:0] m_resp_data;
  bit          m_last_d = 1'b0;   // last granted requester (reset: I)

  initial begin
    forever begin
      logic        e_ig, e_dg, e_mreq, e_mwe, e_iv, e_dv;
      logic [31:0] e_maddr, e_mwdata, e_ird, e_drd;
      logic [3:0]  e_mbe;
      bit          can, w_d, w_i, resp_now;
      logic [31:0] old, nw;
      @(negedge clk);
      e_ig = 0; e_dg = 0; e_mreq = 0; e_mwe = 0; e_iv = 0; e_dv = 0;
      e_maddr = 0; e_mwdata = 0; e_ird = 0; e_drd = 0; e_mbe = 0;
      w_d = 0; w_i = 0;
      if (!rst) begin
        m_resp_cyc = -1;
        m_last_d   = 1'b0;
      end else begin
        resp_now = (m_resp_cyc == cyc);
        can      = (m_resp_cyc < 0) || resp_now;
        if (can) begin
          if (d_req && i_req) begin
`ifdef RV32I_MEM_ARB_RR_EN
            w_d = !m_last_d;
`else
            w_d = 1'b1;
`endif
            w_i = !w_d;
          end else begin
            w_d = d_req;
            w_i = i_req;
          end
        end
        e_ig = w_i; e_dg = w_d; e_mreq = w_i || w_d;
        if (w_d) begin
          e_mwe = d_we; e_maddr = d_addr; e_mwdata = d_wdata; e_mbe = d_be;
        end else if (w_i) begin
          e_maddr = i_addr;
        end
        if (resp_now) begin
          e_iv  = !m_resp_d;
          e_dv  = m_resp_d;
          e_ird = e_iv ? m_resp_data : 32'h0;
          e_drd = e_dv ? m_resp_data : 32'h0;
          m_resp_cyc = -1;
        end
        if (w_i || w_d) begin
          m_resp_cyc  = cyc + LAT;
          m_resp_d    = w_d;
          m_resp_we   = w_d && d_we;
          m_resp_data = mem_rd(w_d ? d_addr : i_addr);
          m_last_d    = w_d;
        end
      end
      check("i_gnt",     i_gnt,     e_ig);
      check("d_gnt",     d_gnt,     e_dg);
      check("mem_req",   mem_req,   e_mreq);
      check("mem_we",    mem_we,    e_mwe);
      check("mem_addr",  mem_addr,  e_maddr);
      check("mem_wdata", mem_wdata, e_mwdata);
      check("mem_be",    mem_be,    e_mbe);
      check("i_rvalid",  i_rvalid,  e_iv);
      check("i_rdata",   i_rdata,   e_ird);
      check("d_rvalid",  d_rvalid,  e_dv);
      if (!(e_dv && m_resp_we)) check("d_rdata", d_rdata, e_drd);

      // event logging for the directed checks
      if (i_gnt) q_ig.push_back(cyc);
      if (d_gnt) begin
        q_dg.push_back(cyc);
        snap_we = mem_we; snap_addr = mem_addr; snap_wdata = mem_wdata; snap_be = mem_be;
      end
      if (i_gnt || d_gnt) q_order.push_back(d_gnt);
      if (i_rvalid) begin q_ir.push_back(cyc); q_ird.push_back(i_rdata); end
      if (d_rvalid) begin q_dr.push_back(cyc); q_drd.push_back(d_rdata); end

      // memory: capture read data for the response cycle, then apply stores
      if (mem_req) begin
        old = mem_rd(mem_addr);
        sched_data[(cyc + LAT) % 8] = old;
        sched_v[(cyc + LAT) % 8]    = 1'b1;
        if (mem_we) begin
          nw = old;
          for (int b = 0; b < 4; b++) if (mem_be[b]) nw[8*b +: 8] = mem_wdata[8*b +: 8];
          mem[mem_addr] = nw;
        end
      end
    end
  end

  // ---------------- memory behind the MEM_LAT=1 instance ----------------
  logic [31:0] nxt1;
  bit          nxt1_v;

  initial begin
    nxt1_v = 1'b0;
    forever begin
      @(negedge clk);
      nxt1_v = mem1_req;
      nxt1   = mem1_addr ^ 32'hA5A5_0000;
    end
  end

  initial begin
    mem1_rdata = 32'hBAD0BAD0;
    forever begin
      @(posedge clk);
      #1;
      mem1_rdata = nxt1_v ? nxt1 : 32'hBAD0BAD0;
    end
  end

  // ---------------- requester tasks (called at posedge + 2) ----------------
  task automatic req_i(input logic [31:0] a);
    bit got = 1'b0;
    i_req = 1'b1; i_addr = a;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (i_gnt) begin got = 1'b1; break; end
    end
    check("i_gnt_wait", got, 1);
    @(posedge clk); #2;
    i_req = 1'b0; i_addr = 32'h0;
  endtask

  task automatic req_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be);
    bit got = 1'b0;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (d_gnt) begin got = 1'b1; break; end
    end
    check("d_gnt_wait", got, 1);
    @(posedge clk); #2;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int  t;
    int  n;
    bit  got;
    bit  exp_d;

    rst = 1'b0;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    i1_req = 0; i1_addr = 0;
    mem[32'h0000_0100] = 32'h00A0_0093;
    mem[32'h0000_2000] = 32'h1122_3344;
    mem[32'h0000_2004] = 32'h5566_7788;

    // reset: requests high, everything must stay 0
    #1;
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h40; d_addr = 32'h80;
    @(negedge clk);
    check("rst_i_gnt", i_gnt, 0);
    check("rst_d_gnt", d_gnt, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_i1_gnt", i1_gnt, 0);
    i_req = 1'b0; d_req = 1'b0; i_addr = 0; d_addr = 0;
    repeat (2) @(posedge clk);
    #2; rst = 1'b1;
    idle_cycles(2);

    // single fetch
    clear_logs();
    req_i(32'h100);
    idle_cycles(4);
    check("s1_i_gnt_count", q_ig.size(), 1);
    check("s1_i_rv_count", q_ir.size(), 1);
    check("s1_i_rv_latency", q_ir[0] - q_ig[0], 2);
    check("s1_i_rdata", q_ird[0], 32'h00A0_0093);
    check("s1_d_gnt_count", q_dg.size(), 0);
    check("s1_d_rv_count", q_dr.size(), 0);

    // simultaneous fetch and load: D first, I back-to-back in the response cycle
    clear_logs();
    fork
      req_i(32'h104);
      req_d(1'b0, 32'h2000, 32'h0, 4'h0);
    join
    idle_cycles(6);
    t = q_dg[0];
    check("s2_first_is_d", q_order[0], 1);
    check("s2_d_rv_cycle", q_dr[0], t + 2);
    check("s2_d_rdata", q_drd[0], 32'h1122_3344);
    check("s2_i_gnt_cycle", q_ig[0], t + 2);
    check("s2_i_rv_cycle", q_ir[0], t + 4);

    // held conflict for four grants
    clear_logs();
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_addr = 32'h2000; d_we = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (i_gnt || d_gnt) n++;
      if (n == 4) break;
    end
    check("s3_grant_count", n, 4);
    @(posedge clk); #2;
    i_req = 1'b0; i_addr = 0; d_req = 1'b0; d_addr = 0;
    idle_cycles(4);
    for (int k = 0; k < 4; k++) begin
`ifdef RV32I_MEM_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      check($sformatf("s3_order_%0d", k), q_order[k], exp_d);
    end

    // store with partial byte enables, then read back
    clear_logs();
    req_d(1'b1, 32'h2004, 32'hDEAD_BEEF, 4'b0011);
    idle_cycles(4);
    check("s4_mem_we", snap_we, 1);
    check("s4_mem_addr", snap_addr, 32'h2004);
    check("s4_mem_wdata", snap_wdata, 32'hDEAD_BEEF);
    check("s4_mem_be", snap_be, 4'b0011);
    check("s4_d_rv_cycle", q_dr[0], q_dg[0] + 2);
    clear_logs();
    req_d(1'b0, 32'h2004, 32'h0, 4'h0);
    idle_cycles(4);
    check("s4_readback", q_drd[0], 32'h5566_BEEF);

    // reset one cycle after a load grant
    clear_logs();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (d_gnt) begin got = 1'b1; break; end
    end
    check("s5_d_gnt_wait", got, 1);
    t = cyc;
    @(posedge clk); #2;
    d_req = 1'b0; d_addr = 0;
    i_req = 1'b1; i_addr = 32'h300;
    rst = 1'b0;
    #1;
    check("s5_async_i_gnt", i_gnt, 0);
    check("s5_async_d_gnt", d_gnt, 0);
    check("s5_async_mem_req", mem_req, 0);
    check("s5_async_i_rvalid", i_rvalid, 0);
    check("s5_async_d_rvalid", d_rvalid, 0);
    check("s5_async_mem_addr", mem_addr, 0);
    @(posedge clk); #2;
    rst = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (i_gnt) begin got = 1'b1; break; end
    end
    check("s5_i_gnt_wait", got, 1);
    @(posedge clk); #2;
    i_req = 1'b0; i_addr = 0;
    idle_cycles(5);
    check("s5_no_d_rvalid", q_dr.size(), 0);
    check("s5_i_gnt_cycle", q_ig[0], t + 2);
    check("s5_i_rv_cycle", q_ir[0], t + 4);

    // MEM_LAT=1 continuous fetch
    i1_req = 1'b1; i1_addr = 32'h400;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("s6_mem_req_%0d", k), mem1_req, 1);
      check($sformatf("s6_i_gnt_%0d", k), i1_gnt, 1);
      check($sformatf("s6_i_rvalid_%0d", k), i1_rvalid, (k > 0));
      if (k > 0)
        check($sformatf("s6_i_rdata_%0d", k), i1_rdata, (32'h400 + 4 * (k - 1)) ^ 32'hA5A5_0000);
      else
        check("s6_i_rdata_0", i1_rdata, 0);
      @(posedge clk); #2;
      if (k < 7) i1_addr = 32'h400 + 4 * (k + 1);
      else begin i1_req = 1'b0; i1_addr = 0; end
    end
    @(negedge clk);
    check("s6_tail_mem_req", mem1_req, 0);
    check("s6_tail_i_rvalid", i1_rvalid, 1);
    check("s6_tail_i_rdata", i1_rdata, (32'h400 + 28) ^ 32'hA5A5_0000);
    @(negedge clk);
    check("s6_idle_i_rvalid", i1_rvalid, 0);

    idle_cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
